// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: kitchen-timer sequencing controller.
// Holds an MM:SS BCD time, edits it from keypad codes, counts it down at
// 1 Hz (derived from the shared 1 kHz pulse), and drives display, finish,
// buzzer and state LEDs.
// Optional build macro: TIMER_SEQ_CTRL_PAUSE_BLINK_EN (blink time in PAUSE).
module timer_seq_ctrl #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned BUZZ_SEC = 5,
  parameter logic [3:0]  BLANK    = 4'hF
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_pls_1k,
  input  logic        i_key_valid,
  input  logic [4:0]  i_bcd_data,
  input  logic        i_start,
  output logic [31:0] o_bcd8d,
  output logic        o_fin,
  output logic        o_buzz_go,
  output logic [3:0]  o_led_op
);

  localparam int unsigned TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BUW = $clog2(BUZZ_SEC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EDIT  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      led_nxt;
  logic [15:0]     tm;
  logic [15:0]     tm_dec;
  logic [15:0]     tm_fix;
  logic [15:0]     shown;
  logic [TW-1:0]   tick_cnt;
  logic [BUW-1:0]  buzz_cnt;
  logic [2:0]      start_sync;
  logic            start_p;
  logic            start_go;
  logic            key_digit;
  logic            key_clr;
  logic            key_set;
  logic            tick;
  logic            run_tick;
  logic            done_tick;
  logic            enter_done;
  logic            leave_done;

  // One BCD second down with minute borrow; 00:00 is never decremented.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] m1, m0, s1, s0;
    {m1, m0, s1, s0} = t;
    if (t != 16'h0000) begin
      if (s0 != 4'd0) begin
        s0 = s0 - 4'd1;
      end else begin
        s0 = 4'd9;
        if (s1 != 4'd0) begin
          s1 = s1 - 4'd1;
        end else begin
          s1 = 4'd5;
          if (m0 != 4'd0) begin
            m0 = m0 - 4'd1;
          end else begin
            m0 = 4'd9;
            m1 = m1 - 4'd1;
          end
        end
      end
    end
    return {m1, m0, s1, s0};
  endfunction

  // Start switch: two-flop synchroniser plus one history flop for rise detect.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) start_sync <= 3'b000;
    else         start_sync <= {start_sync[1:0], i_start};
  end

  assign start_p   = start_sync[1] & ~start_sync[2];
  // A key strobe in the same clock swallows the start edge.
  assign start_go  = start_p & ~i_key_valid;
  assign key_digit = i_key_valid & (i_bcd_data < 5'd10);
  assign key_clr   = i_key_valid & (i_bcd_data == 5'd10);
  assign key_set   = i_key_valid & (i_bcd_data == 5'd11);

  assign tick      = i_pls_1k & (tick_cnt == TW'(TICK_DIV - 1));
  assign run_tick  = (state == S_RUN) & tick;
  assign done_tick = (state == S_DONE) & tick;
  assign tm_dec    = bcd_dec(tm);
  assign tm_fix    = (tm[7:4] > 4'd5) ? {tm[15:8], 8'h59} : tm;

  assign enter_done = (state != S_DONE) & (state_nxt == S_DONE);
  assign leave_done = (state == S_DONE) & (state_nxt != S_DONE);

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // FSM next-state decode; CLEAR beats tick, and a tick reaching 00:00 beats start.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (key_set)                          state_nxt = S_EDIT;
        else if (start_go && tm != 16'h0000)  state_nxt = S_RUN;
      end
      S_EDIT: begin
        if (start_go) state_nxt = (tm_fix != 16'h0000) ? S_RUN : S_IDLE;
      end
      S_RUN: begin
        if (key_clr)                              state_nxt = S_IDLE;
        else if (run_tick && tm_dec == 16'h0000)  state_nxt = S_DONE;
        else if (start_go)                        state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (key_clr)       state_nxt = S_IDLE;
        else if (start_go) state_nxt = S_RUN;
      end
      S_DONE: begin
        if (key_clr || start_go) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: one-hot operation LEDs, dark in DONE.
  always_comb begin
    led_nxt = 4'b0000;
    case (state)
      S_IDLE:  led_nxt = 4'b0001;
      S_EDIT:  led_nxt = 4'b0010;
      S_RUN:   led_nxt = 4'b0100;
      S_PAUSE: led_nxt = 4'b1000;
      default: led_nxt = 4'b0000;
    endcase
  end

  // LED register, trailing the state register by one clock.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_led_op <= 4'b0001;
    else         o_led_op <= led_nxt;
  end

  // Time register: edit shifts, clears, start-time seconds fix-up, countdown.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tm <= 16'h0000;
    end else begin
      case (state)
        S_IDLE: begin
          if (key_set) tm <= 16'h0000;
        end
        S_EDIT: begin
          if (key_digit)     tm <= {tm[11:0], i_bcd_data[3:0]};
          else if (key_clr)  tm <= 16'h0000;
          else if (start_go) tm <= tm_fix;
        end
        S_RUN: begin
          if (key_clr)       tm <= 16'h0000;
          else if (run_tick) tm <= tm_dec;
        end
        S_PAUSE: begin
          if (key_clr) tm <= 16'h0000;
        end
        S_DONE: begin
          if (leave_done) tm <= 16'h0000;
        end
        default: tm <= 16'h0000;
      endcase
    end
  end

  // 1 s divider: runs in RUN and DONE, holds in PAUSE, cleared elsewhere.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tick_cnt <= '0;
    end else begin
      case (state)
        S_RUN, S_DONE: begin
          if (key_clr || leave_done) tick_cnt <= '0;
          else if (tick)             tick_cnt <= '0;
          else if (i_pls_1k)         tick_cnt <= tick_cnt + TW'(1);
        end
        S_PAUSE: begin
          if (key_clr) tick_cnt <= '0;
        end
        default: tick_cnt <= '0;
      endcase
    end
  end

  // Finish flag and buzzer window: buzzer drops on the BUZZ_SEC-th tick in DONE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_fin     <= 1'b0;
      o_buzz_go <= 1'b0;
      buzz_cnt  <= '0;
    end else if (enter_done) begin
      o_fin     <= 1'b1;
      o_buzz_go <= 1'b1;
      buzz_cnt  <= '0;
    end else if (leave_done) begin
      o_fin     <= 1'b0;
      o_buzz_go <= 1'b0;
      buzz_cnt  <= '0;
    end else if (done_tick && o_buzz_go) begin
      if (buzz_cnt == BUW'(BUZZ_SEC - 1)) o_buzz_go <= 1'b0;
      buzz_cnt <= buzz_cnt + BUW'(1);
    end
  end

`ifdef TIMER_SEQ_CTRL_PAUSE_BLINK_EN
  localparam int unsigned BLINK_HALF = 500;
  localparam int unsigned BLW        = $clog2(BLINK_HALF);

  logic [BLW-1:0] blink_cnt;
  logic           blink_dark;

  // Blink phase: restarts visible on every PAUSE entry.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end else if (state != S_PAUSE) begin
      blink_cnt  <= '0;
      blink_dark <= 1'b0;
    end else if (i_pls_1k) begin
      if (blink_cnt == BLW'(BLINK_HALF - 1)) begin
        blink_cnt  <= '0;
        blink_dark <= ~blink_dark;
      end else begin
        blink_cnt <= blink_cnt + BLW'(1);
      end
    end
  end

  assign shown = ((state == S_PAUSE) && blink_dark) ? {4{BLANK}} : tm;
`else
  assign shown = tm;
`endif

  // Display register: upper four digits dark, lower four show the time.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) o_bcd8d <= {{4{BLANK}}, 16'h0000};
    else         o_bcd8d <= {{4{BLANK}}, shown};
  end

endmodule
